// File: rtl/mp_pkg.sv
// mp_pkg: shared defaults, FSM state encoding and limb type for the
// multi-precision limb assembler.
package mp_pkg;

    localparam int N_DEF     = 4096;
    localparam int BLOCK_DEF = 128;
    localparam int MAX_DEF   = N_DEF / BLOCK_DEF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FIX     = 2'd2,
        DONE    = 2'd3
    } state_t;

    // One upstream limb: BLOCK data bits, carry, spare, sign (MSB).
    typedef logic [BLOCK_DEF+2:0] limb_t;

endpackage

// File: rtl/mp_limb_negate.sv
// mp_limb_negate: one limb of a two's-complement negation. The limb output is
// ~limb_i + carry; the carry out is registered so that the next cycle can
// negate the next-higher limb. start seeds the carry with the +1.
module mp_limb_negate
    import mp_pkg::*;
#(
    parameter int BLOCK = BLOCK_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             en,
    input  logic [BLOCK-1:0] limb_i,
    output logic [BLOCK-1:0] limb_o
);

    logic         carry_q;
    logic         carry_d;
    logic [BLOCK:0] sum;

    // Invert the limb and add the carry rippling up from the limb below
    always_comb begin
        sum     = {1'b0, ~limb_i} + {{BLOCK{1'b0}}, carry_q};
        carry_d = carry_q;
        if (start) begin
            carry_d = 1'b1;
        end else if (en) begin
            carry_d = sum[BLOCK];
        end
    end

    assign limb_o = sum[BLOCK-1:0];

    // Carry register between consecutive limbs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

endmodule

// File: rtl/mp_limb_assembler.sv
// mp_limb_assembler: collects signed BLOCK-bit limbs, LSB limb first, into a
// shadow register and publishes the N-bit result with a one-cycle res_vld.
// Build macro MP_ABS_EN: a negative result is converted to its magnitude by a
// limb-serial two's-complement pass (FIX state) before being published.
module mp_limb_assembler
    import mp_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int BLOCK = BLOCK_DEF,
    parameter int MAX   = N / BLOCK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BLOCK+2:0] limb_in,
    input  logic             limb_vld,
    input  logic             limb_last,
    output logic [N-1:0]     res,
    output logic             res_sign,
    output logic             res_cout,
    output logic             res_vld,
    output logic             busy,
    output logic             err
);

    localparam int               CNT_W    = (MAX > 1) ? $clog2(MAX) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     shadow_q, shadow_d;
    logic             sign_q, sign_d;
    logic             cout_q, cout_d;
    logic [N-1:0]     res_q, res_d;
    logic             res_sign_q, res_sign_d;
    logic             res_cout_q, res_cout_d;
    logic             res_vld_q, res_vld_d;
    logic             err_q, err_d;

    logic             capture;
    logic             is_final;
    logic             go_fix;
    logic [CNT_W-1:0] idx;
    logic [BLOCK-1:0] limb_data;
    logic             unused_spare_bit;

    assign limb_data        = limb_in[BLOCK-1:0];
    assign unused_spare_bit = limb_in[BLOCK+1];

    // Decide whether this cycle takes a limb, where it goes, and whether it closes the operand
    always_comb begin
        capture  = limb_vld && ((state_q == IDLE) || (state_q == COLLECT));
        idx      = (state_q == IDLE) ? '0 : cnt_q;
        is_final = limb_last || (idx == LAST_IDX);
`ifdef MP_ABS_EN
        go_fix   = limb_in[BLOCK+2];
`else
        go_fix   = 1'b0;
`endif
    end

`ifdef MP_ABS_EN
    logic [BLOCK-1:0] neg_in;
    logic [BLOCK-1:0] neg_out;
    logic             neg_start;
    logic             neg_en;

    // Pick the shadow limb that the negation pass works on this cycle
    always_comb begin
        neg_in = '0;
        for (int i = 0; i < MAX; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                neg_in = shadow_q[i*BLOCK +: BLOCK];
            end
        end
    end

    assign neg_start = capture && is_final && limb_in[BLOCK+2];
    assign neg_en    = (state_q == FIX);

    mp_limb_negate #(
        .BLOCK (BLOCK)
    ) u_negate (
        .clk    (clk),
        .rst    (rst),
        .start  (neg_start),
        .en     (neg_en),
        .limb_i (neg_in),
        .limb_o (neg_out)
    );
`endif

    // Next-state, shadow collection and hand-off of the shadow into res
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shadow_d   = shadow_q;
        sign_d     = sign_q;
        cout_d     = cout_q;
        res_d      = res_q;
        res_sign_d = res_sign_q;
        res_cout_d = res_cout_q;
        res_vld_d  = 1'b0;
        err_d      = err_q;

        case (state_q)
            IDLE, COLLECT: begin
                if (capture) begin
                    // A new operand starts from zero so a short operand has zero upper limbs
                    if (state_q == IDLE) begin
                        shadow_d = '0;
                    end
                    for (int i = 0; i < MAX; i++) begin
                        if (idx == CNT_W'(i)) begin
                            shadow_d[i*BLOCK +: BLOCK] = limb_data;
                        end
                    end
                    sign_d = limb_in[BLOCK+2];
                    cout_d = limb_in[BLOCK];
                    if (is_final) begin
                        cnt_d = '0;
                        // Early limb_last, or a full operand without limb_last
                        if (limb_last != (idx == LAST_IDX)) begin
                            err_d = 1'b1;
                        end
                        if (go_fix) begin
                            state_d = FIX;
                        end else begin
                            state_d    = DONE;
                            res_d      = shadow_d;
                            res_sign_d = limb_in[BLOCK+2];
                            res_cout_d = limb_in[BLOCK];
                            res_vld_d  = 1'b1;
                        end
                    end else begin
                        cnt_d   = idx + CNT_W'(1);
                        state_d = COLLECT;
                    end
                end
            end
`ifdef MP_ABS_EN
            FIX: begin
                for (int i = 0; i < MAX; i++) begin
                    if (cnt_q == CNT_W'(i)) begin
                        shadow_d[i*BLOCK +: BLOCK] = neg_out;
                    end
                end
                if (limb_vld) begin
                    err_d = 1'b1;
                end
                if (cnt_q == LAST_IDX) begin
                    cnt_d      = '0;
                    state_d    = DONE;
                    res_d      = shadow_d;
                    res_sign_d = sign_q;
                    res_cout_d = cout_q;
                    res_vld_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
                if (limb_vld) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, shadow and output registers; reset clears all of them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shadow_q   <= '0;
            sign_q     <= 1'b0;
            cout_q     <= 1'b0;
            res_q      <= '0;
            res_sign_q <= 1'b0;
            res_cout_q <= 1'b0;
            res_vld_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shadow_q   <= shadow_d;
            sign_q     <= sign_d;
            cout_q     <= cout_d;
            res_q      <= res_d;
            res_sign_q <= res_sign_d;
            res_cout_q <= res_cout_d;
            res_vld_q  <= res_vld_d;
            err_q      <= err_d;
        end
    end

    assign res      = res_q;
    assign res_sign = res_sign_q;
    assign res_cout = res_cout_q;
    assign res_vld  = res_vld_q;
    assign busy     = (state_q != IDLE);
    assign err      = err_q;

endmodule

// File: tb/tb_mp_limb_assembler.sv
// tb_mp_limb_assembler: directed, table-driven bench for mp_limb_assembler
// at its default size (4096-bit operands of 32 x 128-bit limbs).
module tb_mp_limb_assembler;
    import mp_pkg::*;

    localparam int N     = N_DEF;
    localparam int BLOCK = BLOCK_DEF;
    localparam int MAX   = MAX_DEF;

    logic         clk = 1'b0;
    logic         rst;
    limb_t        limb_in;
    logic         limb_vld;
    logic         limb_last;
    logic [N-1:0] res;
    logic         res_sign;
    logic         res_cout;
    logic         res_vld;
    logic         busy;
    logic         err;

    int total = 0;
    int bad   = 0;

    mp_limb_assembler #(
        .N     (N),
        .BLOCK (BLOCK),
        .MAX   (MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .limb_in   (limb_in),
        .limb_vld  (limb_vld),
        .limb_last (limb_last),
        .res       (res),
        .res_sign  (res_sign),
        .res_cout  (res_cout),
        .res_vld   (res_vld),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] fill;      // limb i carries fill ^ (vary ? i : 0)
        logic         vary;
        int           n;         // limbs driven
        logic         use_last;  // raise limb_last on the last driven limb
        logic [2:0]   flags;     // {sign, spare, carry} on the last driven limb
        logic [127:0] exp_fill;  // expected limb i = exp_fill ^ (vary ? i : 0)
        int           exp_n;     // limbs at or above exp_n expected zero
        int           exp_lat;   // cycles from final limb capture to res_vld
        logic         exp_sign;
        logic         exp_cout;
        logic         exp_err;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_res(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        int first;
        total++;
        if (act !== exp) begin
            bad++;
            first = -1;
            for (int i = MAX - 1; i >= 0; i--) begin
                if (act[i*BLOCK +: BLOCK] !== exp[i*BLOCK +: BLOCK]) first = i;
            end
            $display("FAIL %s: limb %0d got %0h want %0h", nm, first,
                     act[first*BLOCK +: BLOCK], exp[first*BLOCK +: BLOCK]);
        end
    endtask

    function automatic logic [N-1:0] build_exp(input logic [127:0] fill, input logic vary,
                                               input int n);
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < n; i++) begin
            r[i*BLOCK +: BLOCK] = fill ^ (vary ? 128'(i) : 128'd0);
        end
        return r;
    endfunction

    // Called at a falling edge; leaves the bench at a falling edge.
    task automatic do_reset();
        rst       = 1'b1;
        limb_vld  = 1'b0;
        limb_last = 1'b0;
        limb_in   = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drive one operand starting at the current falling edge, then check the
    // published result. prev is the res value that must hold during collection.
    // poke_done drives an extra limb during the res_vld (DONE) cycle.
    task automatic run_op(input vec_t v, input logic [N-1:0] prev, input string nm,
                          input logic poke_done);
        logic         early;
        logic         held;
        int           lat;
        logic [N-1:0] expv;
        early = 1'b0;
        held  = 1'b1;
        lat   = 0;
        expv  = build_exp(v.exp_fill, v.vary, v.exp_n);
        for (int i = 0; i < v.n; i++) begin
            limb_vld  = 1'b1;
            limb_last = v.use_last && (i == v.n - 1);
            limb_in   = {(i == v.n - 1) ? v.flags : 3'b000,
                         v.fill ^ (v.vary ? 128'(i) : 128'd0)};
            @(negedge clk);
            if (i < v.n - 1) begin
                if (res_vld) early = 1'b1;
                if (res !== prev) held = 1'b0;
            end
        end
        limb_vld  = 1'b0;
        limb_last = 1'b0;
        limb_in   = '0;
        if (res_vld) lat = 1;
        for (int c = 2; c <= 40 && lat == 0; c++) begin
            @(negedge clk);
            if (res_vld) lat = c;
        end
        chk({nm, " latency"}, 128'(lat), 128'(v.exp_lat));
        chk({nm, " early_vld"}, 128'(early), 128'd0);
        chk({nm, " res_held"}, 128'(held), 128'd1);
        chk_res({nm, " res"}, res, expv);
        chk({nm, " res_sign"}, 128'(res_sign), 128'(v.exp_sign));
        chk({nm, " res_cout"}, 128'(res_cout), 128'(v.exp_cout));
        chk({nm, " err"}, 128'(err), 128'(v.exp_err));
        if (poke_done) begin
            limb_vld  = 1'b1;
            limb_last = 1'b1;
            limb_in   = {3'b101, 128'h999};
        end
        @(negedge clk);
        limb_vld  = 1'b0;
        limb_last = 1'b0;
        limb_in   = '0;
        chk({nm, " vld_pulse"}, 128'(res_vld), 128'd0);
        chk({nm, " idle"}, 128'(busy), 128'd0);
    endtask

    initial begin
        int           seen;
        logic [N-1:0] exp_a;
        vec_t         va;
        vec_t         vb;

        //           fill                                      vary n   last flags    exp_fill                                 exp_n lat sign cout err
        vt[0] = '{128'h1,                                  1'b0, 32, 1'b1, 3'b000, 128'h1,                                  32, 1, 1'b0, 1'b0, 1'b0};
        vt[1] = '{128'h0123456789abcdeffedcba9876543210,   1'b1, 32, 1'b1, 3'b001, 128'h0123456789abcdeffedcba9876543210,   32, 1, 1'b0, 1'b1, 1'b0};
`ifdef MP_ABS_EN
        vt[2] = '{{128{1'b1}},                             1'b0, 32, 1'b1, 3'b100, 128'h1,                                  1,  33, 1'b1, 1'b0, 1'b0};
`else
        vt[2] = '{{128{1'b1}},                             1'b0, 32, 1'b1, 3'b100, {128{1'b1}},                             32, 1, 1'b1, 1'b0, 1'b0};
`endif
        vt[3] = '{128'h55555555555555555555555555555555,   1'b1, 4,  1'b1, 3'b000, 128'h55555555555555555555555555555555,   4,  1, 1'b0, 1'b0, 1'b1};
        vt[4] = '{128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5,   1'b1, 32, 1'b0, 3'b011, 128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5,   32, 1, 1'b0, 1'b1, 1'b1};
        vt[5] = '{128'h7,                                  1'b0, 1,  1'b1, 3'b001, 128'h7,                                  1,  1, 1'b0, 1'b1, 1'b1};

        // Reset state, sampled while rst is held
        rst       = 1'b1;
        limb_vld  = 1'b0;
        limb_last = 1'b0;
        limb_in   = '0;
        @(negedge clk);
        @(negedge clk);
        chk_res("reset res", res, '0);
        chk("reset res_vld", 128'(res_vld), 128'd0);
        chk("reset res_sign", 128'(res_sign), 128'd0);
        chk("reset res_cout", 128'(res_cout), 128'd0);
        chk("reset busy", 128'(busy), 128'd0);
        chk("reset err", 128'(err), 128'd0);
        rst = 1'b0;
        @(negedge clk);

        // Table of single operands, each from a fresh reset
        for (int k = 0; k < 6; k++) begin
            do_reset();
            run_op(vt[k], '0, $sformatf("vec%0d", k), 1'b0);
        end

        // Limb during DONE is dropped and raises err on an otherwise clean operand
        do_reset();
        run_op(vt[0], '0, "drop", 1'b1);
        chk("drop err_set", 128'(err), 128'd1);
        @(negedge clk);
        chk("drop no_vld", 128'(res_vld), 128'd0);
        chk("drop still_idle", 128'(busy), 128'd0);
        chk_res("drop res_kept", res, build_exp(vt[0].exp_fill, 1'b0, 32));

        // Short operand then a DONE-cycle limb: upper limbs zero, err stays set
        do_reset();
        run_op(vt[3], '0, "short_drop", 1'b1);
        chk("short_drop err", 128'(err), 128'd1);
        chk_res("short_drop res", res, build_exp(vt[3].exp_fill, 1'b1, 4));

        // Back-to-back operands: the second starts in the first IDLE cycle after DONE
        do_reset();
        va = vt[1];
        vb = vt[1];
        vb.fill     = 128'hcafef00d_00000000_11111111_22222222;
        vb.exp_fill = vb.fill;
        vb.flags    = 3'b000;
        vb.exp_cout = 1'b0;
        exp_a = build_exp(va.exp_fill, 1'b1, 32);
        run_op(va, '0, "b2b_a", 1'b0);
        run_op(vb, exp_a, "b2b_b", 1'b0);

        // Reset after limb 10 aborts the operand; a fresh operand then assembles
        do_reset();
        for (int i = 0; i <= 10; i++) begin
            limb_vld  = 1'b1;
            limb_last = 1'b0;
            limb_in   = {3'b000, 128'h3c ^ 128'(i)};
            @(negedge clk);
        end
        limb_vld = 1'b0;
        limb_in  = '0;
        chk("abort busy_before", 128'(busy), 128'd1);
        rst = 1'b1;
        #1;
        chk("abort busy", 128'(busy), 128'd0);
        chk("abort res_vld", 128'(res_vld), 128'd0);
        chk_res("abort res", res, '0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (res_vld) seen++;
        end
        chk("abort no_vld", 128'(seen), 128'd0);
        run_op(vt[1], '0, "after_abort", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
